fetch_unit: RTL and testbench

Program-counter and fetch stage that sits directly upstream of the instruction ROM.
- Drives the combinational ROM address.
- Captures the returned 9-bit instruction with its PC into a small fetch buffer.
- Presents instructions to the decode stage over a valid/ready handshake.
- Handles stall back-pressure, run enable, and PC redirect (flush) from execute.

---
 rtl/fetch_if.sv | 12 +
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Decode-side valid/ready handshake between the fetch buffer head and decode.
interface fetch_if #(
  parameter int PC_W = 4
) ();
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_instr;
  logic [PC_W-1:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_unit.sv
// PC register plus circular fetch buffer in front of a combinational instruction ROM.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_unit #(
  parameter int              PC_W      = 4,
  parameter int              BUF_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  output logic [PC_W-1:0]                pc_addr,
  input  logic [8:0]                     instr_in,
  input  logic                           redirect_valid,
  input  logic [PC_W-1:0]                redirect_pc,
  fetch_if.master                        dec,
`ifdef FETCH_PERF_EN
  output logic [15:0]                    perf_fetch_cnt,
  output logic [15:0]                    perf_stall_cnt,
`endif
  output logic [$clog2(BUF_DEPTH):0]     buf_count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [8:0]       instr_mem [BUF_DEPTH];
  logic [PC_W-1:0]  pc_mem    [BUF_DEPTH];

  logic full, empty, pop, push, stall;

  assign full  = (count == CNT_W'(BUF_DEPTH));
  assign empty = (count == '0);
  assign pop   = dec.out_valid & dec.out_ready;
  assign push  = run & ~redirect_valid & (~full | pop);
  assign stall = run & ~redirect_valid & full & ~pop;

  assign pc_addr       = pc;
  assign buf_count     = count;
  assign dec.out_valid = ~empty;
  assign dec.out_instr = empty ? 9'd0 : instr_mem[rd_ptr];
  assign dec.out_pc    = empty ? '0 : pc_mem[rd_ptr];

  // Redirect flushes everything; a pop in that cycle is simply absorbed by the flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + PC_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; empty-gating on the outputs hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= instr_in;
      pc_mem[wr_ptr]    <= pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != 16'hFFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (stall && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with a small ROM table driven from pc_addr.
module tb_fetch_unit;
  localparam int PC_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run;
  logic [PC_W-1:0] pc_addr;
  logic [8:0]      instr_in;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [1:0]      buf_count;
`ifdef FETCH_PERF_EN
  logic [15:0]     perf_fetch_cnt, perf_stall_cnt;
`endif
  logic [8:0]      rom [16];

  int n_chk  = 0;
  int n_pass = 0;

  fetch_if #(.PC_W(PC_W)) dec_if ();

  fetch_unit #(.PC_W(PC_W), .BUF_DEPTH(2), .RESET_PC(4'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .pc_addr        (pc_addr),
    .instr_in       (instr_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec_if.master),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .buf_count      (buf_count)
  );

  always #5 clk = ~clk;
  assign instr_in = rom[pc_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry: 1 ns after an edge. Reset pulse stays clear of the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_head(input string tag, input int exp_pc, input int exp_cnt);
    chk({tag, "_valid"}, 32'(dec_if.out_valid), 32'(exp_cnt != 0));
    chk({tag, "_pc"},    32'(dec_if.out_pc),    32'(exp_pc));
    chk({tag, "_instr"}, 32'(dec_if.out_instr), 32'(rom[exp_pc]));
    chk({tag, "_cnt"},   32'(buf_count),        32'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 9'((i * 37 + 3) % 512);
    rom[1] = 9'h035;
    rom[4] = 9'h0CB;

    rst_n = 1'b0; run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    dec_if.out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(dec_if.out_valid), 0);
    chk("rst_cnt",   32'(buf_count), 0);
    chk("rst_pc",    32'(pc_addr), 0);
    chk("rst_instr", 32'(dec_if.out_instr), 0);
    chk("rst_opc",   32'(dec_if.out_pc), 0);
    #10 rst_n = 1'b1;

    // streaming: one instruction per cycle, out_pc one behind pc_addr
    run = 1'b1; dec_if.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("str_pcaddr", 32'(pc_addr), 32'(k + 1));
      chk_head("str", k, 1);
    end
    chk("str_rom1_const", 32'(rom[1]), 32'h035);

    // back-pressure: fill, stall, then drain with simultaneous push/pop
    tick(); do_reset();
    dec_if.out_ready = 1'b0;
    tick(); chk("bp_cnt1", 32'(buf_count), 1);
    tick(); chk("bp_cnt2", 32'(buf_count), 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pcaddr", 32'(pc_addr), 2);
      chk_head("stall", 0, 2);
    end
`ifdef FETCH_PERF_EN
    chk("perf_stall3", 32'(perf_stall_cnt), 3);
    chk("perf_fetch2", 32'(perf_fetch_cnt), 2);
`endif
    dec_if.out_ready = 1'b1;
    tick(); chk_head("drainA", 1, 2); chk("drainA_pcaddr", 32'(pc_addr), 3);
    tick(); chk_head("drainB", 2, 2); chk("drainB_pcaddr", 32'(pc_addr), 4);

    // run low: buffer drains, pc holds, resume at held pc
    run = 1'b0;
    tick(); chk_head("runoffC", 3, 1); chk("runoffC_pcaddr", 32'(pc_addr), 4);
    tick();
    chk("runoffD_valid", 32'(dec_if.out_valid), 0);
    chk("runoffD_instr", 32'(dec_if.out_instr), 0);
    chk("runoffD_opc",   32'(dec_if.out_pc), 0);
    chk("runoffD_cnt",   32'(buf_count), 0);
    chk("runoffD_pcaddr", 32'(pc_addr), 4);
    run = 1'b1;
    tick(); chk_head("resume", 4, 1);

    // free-run across the 15 -> 0 wrap
    for (int i = 0; i < 18; i++) begin
      tick();
      chk_head("wrap", (5 + i) % 16, 1);
    end
`ifdef FETCH_PERF_EN
    chk("perf_stall_wrap", 32'(perf_stall_cnt), 3);
`endif

    // redirect while holding two entries
    dec_if.out_ready = 1'b0;
    tick(); chk("redir_pre_cnt", 32'(buf_count), 2);
    chk("redir_pre_opc", 32'(dec_if.out_pc), 6);
    redirect_valid = 1'b1; redirect_pc = 4'd4;
    tick();
    chk("redir_valid",  32'(dec_if.out_valid), 0);
    chk("redir_cnt",    32'(buf_count), 0);
    chk("redir_pcaddr", 32'(pc_addr), 4);
    redirect_valid = 1'b0; dec_if.out_ready = 1'b1;
    tick(); chk_head("redir_first", 4, 1);
    chk("redir_instr_0cb", 32'(dec_if.out_instr), 32'h0CB);
    chk("redir_first_pcaddr", 32'(pc_addr), 5);

    // redirect loads pc even with run low
    run = 1'b0; redirect_valid = 1'b1; redirect_pc = 4'd9;
    tick();
    chk("redir_norun_valid",  32'(dec_if.out_valid), 0);
    chk("redir_norun_pcaddr", 32'(pc_addr), 9);
    redirect_valid = 1'b0;
    tick(); chk("redir_norun_hold", 32'(pc_addr), 9);
    run = 1'b1;
    tick(); chk_head("redir_norun_first", 9, 1);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_total", 32'(perf_fetch_cnt), 26);
    chk("perf_stall_total", 32'(perf_stall_cnt), 3);
`endif

    // asynchronous reset mid-stream
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(dec_if.out_valid), 0);
    chk("arst_pcaddr", 32'(pc_addr), 0);
    chk("arst_cnt",    32'(buf_count), 0);
`ifdef FETCH_PERF_EN
    chk("arst_perf", 32'(perf_fetch_cnt), 0);
`endif
    #2 rst_n = 1'b1;
    tick(); chk_head("arst_restart", 0, 1);
    chk("arst_restart_pcaddr", 32'(pc_addr), 1);
    tick(); chk_head("arst_restart2", 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
